// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands one bit pair per cycle,
// LSB first, and presents the registered sum and carry after WIDTH cycles.
module serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [1:0]       fa;

  // One-bit full adder; returns {carry, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  assign fa      = full_add(a_sr[0], b_sr[0], c);
  assign res_nxt = {fa[0], res_sr[WIDTH-1:1]};
  // The final bit pair is processed while the counter reads WIDTH-1.
  assign last    = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and status outputs decoded from the current state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, serial add, and result load on the final RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            c    <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          c      <= fa[1];
          cnt    <= cnt + 1'b1;
          if (last) begin
            sum       <= res_nxt;
            carry_out <= fa[1];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=16 and WIDTH=4.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start16;
  logic [15:0] a16, b16, sum16;
  logic        busy16, done16, co16;
  logic        start4;
  logic [3:0]  a4, b4, sum4;
  logic        busy4, done4, co4;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] prev_sum;
  logic        prev_co;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .carry_out(co16)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(co4)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        co;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One 16-bit add. inj >= 0 re-pulses start with all-ones operands at that RUN
  // index; inj < 0 scrambles the operand inputs every RUN cycle instead.
  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] es, input logic eco, input int inj);
    @(negedge clk);
    rst_n = 1'b1; a16 = a; b16 = b; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("busy_run", {30'd0, busy16, done16}, 32'b10);
      chk("hold_run", {15'd0, co16, sum16}, {15'd0, prev_co, prev_sum});
      if (inj >= 0 && i == inj) begin
        start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF;
      end else begin
        start16 = 1'b0;
        if (inj < 0) begin
          a16 = 16'($urandom); b16 = 16'($urandom);
        end
      end
      @(negedge clk);
    end
    chk("done_pulse", {30'd0, busy16, done16}, 32'b01);
    chk("result", {15'd0, co16, sum16}, {15'd0, eco, es});
    @(negedge clk);
    chk("done_clear", {30'd0, busy16, done16}, 32'b00);
    chk("result_hold", {15'd0, co16, sum16}, {15'd0, eco, es});
    prev_sum = es; prev_co = eco;
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] exp;
    int lat;
    exp = {1'b0, a} + {1'b0, b};
    @(negedge clk);
    a4 = a; b4 = b; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 1;
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency4", lat, 5);
    chk("result4", {27'd0, co4, sum4}, {27'd0, exp});
    @(negedge clk);
    chk("done4_clear", {31'd0, done4}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    logic [15:0] ra, rb;
    logic [16:0] rexp;

    tbl[0] = '{16'h0003, 16'h0005, 16'h0008, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    tbl[3] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
    tbl[4] = '{16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0};
    tbl[5] = '{16'h8001, 16'h8001, 16'h0002, 1'b1};

    rst_n = 1'b1; start16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222;
    start4 = 1'b1; a4 = 4'h3; b4 = 4'h4;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_state16", {13'd0, busy16, done16, co16, sum16}, 32'd0);
    chk("reset_state4", {25'd0, busy4, done4, co4, sum4}, 32'd0);
    repeat (3) @(negedge clk);
    chk("reset_held16", {13'd0, busy16, done16, co16, sum16}, 32'd0);
    start16 = 1'b0; start4 = 1'b0;
    rst_n = 1'b1;
    prev_sum = 16'h0; prev_co = 1'b0;

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run16(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].co, -1);
    end

    // Start re-pulsed mid-operation must be ignored.
    run16(16'h1234, 16'h4321, 16'h5555, 1'b0, 4);

    // Reset during RUN aborts the add.
    @(negedge clk);
    a16 = 16'h00FF; b16 = 16'h0001; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy16}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy16}, 32'd0);
    chk("abort_result", {15'd0, co16, sum16}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_sum = 16'h0; prev_co = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", {13'd0, busy16, done16, co16, sum16}, 32'd0);
    end
    // Start on the first edge after reset release.
    @(negedge clk);
    rst_n = 1'b0;
    run16(16'h0002, 16'h0002, 16'h0004, 1'b0, -1);

    // Back-to-back with start held high.
    @(negedge clk);
    a16 = 16'h8000; b16 = 16'h8000; start16 = 1'b1;
    for (int k = 0; k < 54; k++) begin
      @(negedge clk);
      chk("b2b_busy", {31'd0, busy16}, {31'd0, (k % 18) <= 15});
      chk("b2b_done", {31'd0, done16}, {31'd0, (k % 18) == 16});
      if ((k % 18) == 16) begin
        prev_sum = 16'h0000; prev_co = 1'b1;
      end
      chk("b2b_result", {15'd0, co16, sum16}, {15'd0, prev_co, prev_sum});
      if (k == 53) start16 = 1'b0;
    end
    @(negedge clk);
    chk("b2b_stopped", {30'd0, busy16, done16}, 32'd0);

    // Randomized 16-bit adds against plain arithmetic.
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rexp = {1'b0, ra} + {1'b0, rb};
      run16(ra, rb, rexp[15:0], rexp[16], -1);
    end

    // WIDTH=4: exhaustive plus random.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run4(4'(x), 4'(y));
      end
    end
    for (int i = 0; i < 40; i++) begin
      run4(4'($urandom), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
